// File: rtl/midi_floppy_ctrl_if.sv
// Byte-stream in / floppy-drive setpoints out, bundled for the MIDI note controller.
// Ports: rx_data/new_rx_data (one-cycle byte strobe, no ready), f0_sp/f0_en and f1_sp/f1_en
// per-drive setpoint and enable, active_note LED byte. slave = controller side, master = source/observer.
`timescale 1ns/1ps
interface midi_floppy_ctrl_if #(parameter int SP_W = 22);
  logic [7:0]      rx_data;
  logic            new_rx_data;
  logic [SP_W-1:0] f0_sp;
  logic            f0_en;
  logic [SP_W-1:0] f1_sp;
  logic            f1_en;
  logic [7:0]      active_note;

  modport slave  (input  rx_data, new_rx_data,
                  output f0_sp, f0_en, f1_sp, f1_en, active_note);
  modport master (output rx_data, new_rx_data,
                  input  f0_sp, f0_en, f1_sp, f1_en, active_note);
endinterface

// File: rtl/midi_floppy_ctrl.sv
// MIDI note-on/off parser + note-to-step-period converter driving two floppy step drivers.
// Latency: velocity byte at cycle 0 -> f*_sp/f*_en visible in cycle 2 (decode reg + lookup/shift reg).
// Backpressure: none; accepts a byte every cycle, never stalls, no ready signal.
// Ports: clk, rst_n (sync, active low), bus (slave modport: rx_data/new_rx_data in;
//   f0_sp/f0_en, f1_sp/f1_en, active_note out). SP_W must not exceed 24.
// Build option: MIDI_ALLOC_EN -> CH0 only, notes allocated dynamically over both drives
//   (idle drive first, else steal the older note); undefined -> static CH0/CH1 mapping.
`timescale 1ns/1ps
module midi_floppy_ctrl #(
  parameter logic [3:0] CH0  = 4'd0,
  parameter logic [3:0] CH1  = 4'd1,
  parameter int         SP_W = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  midi_floppy_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_NOTE, WAIT_VEL} state_t;

  localparam logic [23:0] SP_MAX = 24'((64'd1 << SP_W) - 64'd1);

  // ---------------- parser ----------------
  state_t     state_q, state_d;
  logic [4:0] stat_q, stat_d;   // {is_note_on_status, channel}
  logic [6:0] note_q, note_d;
  logic       msg_vld;
  logic       msg_on;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stat_q  <= '0;
      note_q  <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      note_q  <= note_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    note_d  = note_q;
    msg_vld = 1'b0;
    if (bus.new_rx_data) begin
      if (bus.rx_data[7]) begin
        if (bus.rx_data[7:3] == 5'b11111) begin
          // realtime bytes may interleave anywhere and must not disturb the parse
        end else if (bus.rx_data[7:5] == 3'b100) begin
          stat_d  = bus.rx_data[4:0];
          state_d = WAIT_NOTE;
        end else begin
          state_d = IDLE;   // other status kills running status
        end
      end else begin
        case (state_q)
          WAIT_NOTE: begin
            note_d  = bus.rx_data[6:0];
            state_d = WAIT_VEL;
          end
          WAIT_VEL: begin
            msg_vld = 1'b1;
            state_d = WAIT_NOTE;   // running status: next data byte is a new note
          end
          default: ;
        endcase
      end
    end
  end

  // 0x9n with velocity 0 is a note-off
  assign msg_on = stat_q[4] && (bus.rx_data[6:0] != 7'd0);

  // ---------------- stage 1: decode ----------------
  logic       s1_vld;
  logic       s1_on;
  logic [6:0] s1_note;
`ifdef MIDI_ALLOC_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_on   <= 1'b0;
      s1_note <= '0;
    end else begin
      s1_vld  <= msg_vld && (stat_q[3:0] == CH0);
      s1_on   <= msg_on;
      s1_note <= note_q;
    end
  end
`else
  logic s1_drv;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_on   <= 1'b0;
      s1_note <= '0;
      s1_drv  <= 1'b0;
    end else begin
      s1_vld  <= msg_vld && ((stat_q[3:0] == CH0) || (stat_q[3:0] == CH1));
      s1_drv  <= (stat_q[3:0] != CH0);   // CH0 wins when CH1==CH0
      s1_on   <= msg_on;
      s1_note <= note_q;
    end
  end
`endif

  // ---------------- stage 2: period lookup/shift ----------------
  logic [3:0]      oct, key;
  logic [23:0]     base, shifted;
  logic [SP_W-1:0] period;

  always_comb begin
    oct = 4'(s1_note / 7'd12);
    key = 4'(s1_note % 7'd12);
    case (key)
      4'd0:    base = 24'd6115607;
      4'd1:    base = 24'd5772339;
      4'd2:    base = 24'd5448404;
      4'd3:    base = 24'd5142604;
      4'd4:    base = 24'd4853993;
      4'd5:    base = 24'd4581524;
      4'd6:    base = 24'd4324399;
      4'd7:    base = 24'd4081666;
      4'd8:    base = 24'd3852584;
      4'd9:    base = 24'd3636364;
      4'd10:   base = 24'd3432275;
      default: base = 24'd3239622;
    endcase
    shifted = base >> oct;
    period  = (shifted > SP_MAX) ? SP_MAX[SP_W-1:0] : shifted[SP_W-1:0];
  end

  logic [SP_W-1:0] sp0_q, sp1_q;
  logic            en0_q, en1_q;
  logic [6:0]      n0_q, n1_q;
  logic            hit0, hit1;
  logic [1:0]      wr_on, wr_off;

  // Stage 2 reads the committed drive state, so an off right behind an on sees its note.
  assign hit0 = en0_q && (n0_q == s1_note);
  assign hit1 = en1_q && (n1_q == s1_note);

`ifdef MIDI_ALLOC_EN
  logic older_q;   // drive holding the older note-on; victim when both busy
  logic tgt;

  always_comb begin
    if (hit0)        tgt = 1'b0;   // retrigger reuses the holding drive
    else if (hit1)   tgt = 1'b1;
    else if (!en0_q) tgt = 1'b0;
    else if (!en1_q) tgt = 1'b1;
    else             tgt = older_q;
  end

  assign wr_on  = {s1_vld && s1_on && tgt, s1_vld && s1_on && !tgt};
  assign wr_off = {s1_vld && !s1_on && hit1 && !hit0, s1_vld && !s1_on && hit0};

  always_ff @(posedge clk) begin
    if (!rst_n)                older_q <= 1'b0;
    else if (s1_vld && s1_on)  older_q <= ~tgt;
  end
`else
  assign wr_on  = {s1_vld && s1_on && s1_drv, s1_vld && s1_on && !s1_drv};
  assign wr_off = {s1_vld && !s1_on && s1_drv && hit1, s1_vld && !s1_on && !s1_drv && hit0};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp0_q <= '0; en0_q <= 1'b0; n0_q <= '0;
      sp1_q <= '0; en1_q <= 1'b0; n1_q <= '0;
    end else begin
      if (wr_on[0]) begin
        n0_q <= s1_note; sp0_q <= period; en0_q <= 1'b1;
      end else if (wr_off[0]) begin
        en0_q <= 1'b0;   // setpoint held on release
      end
      if (wr_on[1]) begin
        n1_q <= s1_note; sp1_q <= period; en1_q <= 1'b1;
      end else if (wr_off[1]) begin
        en1_q <= 1'b0;
      end
    end
  end

  assign bus.f0_sp       = sp0_q;
  assign bus.f0_en       = en0_q;
  assign bus.f1_sp       = sp1_q;
  assign bus.f1_en       = en1_q;
  assign bus.active_note = {en0_q | en1_q, en1_q ? n1_q : n0_q};

endmodule
